// File: rtl/phy_link_poll_pkg.sv
// Shared constants and types for the per-port MDIO link poller: speed codes,
// MDIO frame fields and the bit layout of the PHY-specific status register.
package phy_link_poll_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam int unsigned SB_SPD_HI   = 15;
  localparam int unsigned SB_SPD_LO   = 14;
  localparam int unsigned SB_DUPLEX   = 13;
  localparam int unsigned SB_RESOLVED = 11;
  localparam int unsigned SB_LINK     = 10;

  // Bit counter reload values: index of the first bit driven/sampled in each phase.
  localparam logic [5:0] PRE_LAST  = 6'd31;
  localparam logic [5:0] CMD_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  typedef enum logic [2:0] {
    ST_WAIT, ST_REQ, ST_PRE, ST_CMD, ST_TA, ST_DATA, ST_DONE
  } poll_state_e;

  typedef struct packed {
    logic       up;
    logic [1:0] speed;
    logic       duplex;
  } link_stat_t;

  // The reserved speed code is reported as 10M.
  function automatic logic [1:0] map_speed(input logic [1:0] raw);
    case (raw)
      SPD_100:  return SPD_100;
      SPD_1000: return SPD_1000;
      default:  return SPD_10;
    endcase
  endfunction

endpackage

// File: rtl/phy_link_poll_if.sv
// MDIO pin bundle plus the req/gnt arbitration pair shared with the MAC-side management path.
interface phy_link_poll_if;
  logic mdio_req;
  logic mdio_gnt;
  logic mdc;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;

  modport master (output mdio_req, mdc, mdio_o, mdio_oe, input mdio_gnt, mdio_i);
  modport slave  (input mdio_req, mdc, mdio_o, mdio_oe, output mdio_gnt, mdio_i);
endinterface

// File: rtl/phy_link_poll_clkgen.sv
// MDC divider: low phase first, with single-cycle strobes on the clk where mdc rises/falls.
module mdio_clkgen #(
  parameter int unsigned MDC_HALF = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic mdc_o,
  output logic fall_stb_o,
  output logic rise_stb_o
);
  localparam int unsigned CW = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;

  logic [CW-1:0] cnt_q;
  logic          mdc_q;
  logic          half_end;

  assign half_end   = run_i && (cnt_q == CW'(MDC_HALF - 1));
  assign rise_stb_o = half_end & ~mdc_q;
  assign fall_stb_o = half_end &  mdc_q;
  assign mdc_o      = mdc_q;

  // Dropping run parks mdc low on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (!run_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (half_end) begin
      cnt_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/phy_link_poll.sv
// Periodic MDIO read of one PHY status register; publishes link up/speed/duplex for one port.
module phy_link_poll
  import phy_link_poll_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR    = 5'd0,
  parameter logic [4:0]  STAT_REG    = 5'd17,
  parameter int unsigned MDC_HALF    = 7,
  parameter int unsigned POLL_CYCLES = 3300000,
  parameter int unsigned GNT_TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  phy_link_poll_if.master        mdio,
  output logic                   phy_up_o,
  output logic [1:0]             phy_speed_o,
  output logic                   phy_duplex_o,
  output logic                   link_change_o,
  output logic                   poll_err_o
);
  localparam int unsigned TMAX = (POLL_CYCLES > GNT_TIMEOUT) ? POLL_CYCLES : GNT_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [13:0]   CMD_WORD  = {MDIO_ST, MDIO_OP_RD, PHY_ADDR, STAT_REG};
  localparam logic [TW-1:0] POLL_LOAD = TW'(POLL_CYCLES);
  localparam logic [TW-1:0] GNT_LOAD  = TW'(GNT_TIMEOUT - 1);

  poll_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic [15:0]   sh_q, sh_d;
  logic          mdo_q, mdo_d;
  logic          oe_q, oe_d;
  logic          ta_q, ta_d;
  logic          err_q, err_d;
  link_stat_t    stat_q, stat_d, stat_prev_q;
  logic          lc_q;
  logic          in_frame, mdc, fall_stb, rise_stb;
  logic [3:0]    cmd_idx;

  assign in_frame = state_q inside {ST_PRE, ST_CMD, ST_TA, ST_DATA};
  assign cmd_idx  = bitcnt_q[3:0] - 4'd1;

  mdio_clkgen #(.MDC_HALF(MDC_HALF)) u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (in_frame & mdio.mdio_gnt),
    .mdc_o      (mdc),
    .fall_stb_o (fall_stb),
    .rise_stb_o (rise_stb)
  );

  // Timer counts down the poll interval in WAIT and the grant budget in REQ.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    mdo_d    = mdo_q;
    oe_d     = oe_q;
    ta_d     = ta_q;
    err_d    = err_q;
    stat_d   = stat_q;
    case (state_q)
      ST_WAIT: begin
        if (timer_q == '0) begin
          state_d = ST_REQ;
          timer_d = GNT_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_REQ: begin
        if (mdio.mdio_gnt) begin
          state_d  = ST_PRE;
          bitcnt_d = PRE_LAST;
          mdo_d    = 1'b1;
          oe_d     = 1'b1;
        end else if (timer_q == '0) begin
          state_d = ST_WAIT;
          err_d   = 1'b1;
          timer_d = POLL_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_PRE, ST_CMD, ST_TA, ST_DATA: begin
        if (!mdio.mdio_gnt) begin
          // Lost the bus: release immediately and leave the published status alone.
          state_d = ST_WAIT;
          oe_d    = 1'b0;
          mdo_d   = 1'b1;
          err_d   = 1'b1;
          timer_d = POLL_LOAD;
        end else begin
          if (rise_stb) begin
            if (state_q == ST_TA && bitcnt_q == '0) ta_d = mdio.mdio_i;
            if (state_q == ST_DATA) sh_d = {sh_q[14:0], mdio.mdio_i};
          end
          if (fall_stb) begin
            if (bitcnt_q != '0) begin
              bitcnt_d = bitcnt_q - 1'b1;
              if (state_q == ST_CMD) mdo_d = CMD_WORD[cmd_idx];
            end else begin
              case (state_q)
                ST_PRE: begin
                  state_d  = ST_CMD;
                  bitcnt_d = CMD_LAST;
                  mdo_d    = CMD_WORD[13];
                end
                ST_CMD: begin
                  state_d  = ST_TA;
                  bitcnt_d = TA_LAST;
                  oe_d     = 1'b0;
                  mdo_d    = 1'b1;
                end
                ST_TA: begin
                  state_d  = ST_DATA;
                  bitcnt_d = DATA_LAST;
                end
                default: state_d = ST_DONE;
              endcase
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_WAIT;
        timer_d = POLL_LOAD;
        if (ta_q) begin
          // Pulled-up turnaround means nobody answered.
          err_d     = 1'b1;
          stat_d.up = 1'b0;
        end else begin
          err_d         = 1'b0;
          stat_d.up     = sh_q[SB_LINK] & sh_q[SB_RESOLVED];
          stat_d.speed  = map_speed(sh_q[SB_SPD_HI:SB_SPD_LO]);
          stat_d.duplex = sh_q[SB_DUPLEX];
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      timer_q     <= '0;
      bitcnt_q    <= '0;
      sh_q        <= '0;
      mdo_q       <= 1'b1;
      oe_q        <= 1'b0;
      ta_q        <= 1'b1;
      err_q       <= 1'b0;
      stat_q      <= '0;
      stat_prev_q <= '0;
      lc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bitcnt_q    <= bitcnt_d;
      sh_q        <= sh_d;
      mdo_q       <= mdo_d;
      oe_q        <= oe_d;
      ta_q        <= ta_d;
      err_q       <= err_d;
      stat_q      <= stat_d;
      stat_prev_q <= stat_q;
      lc_q        <= (stat_q != stat_prev_q);
    end
  end

  assign mdio.mdio_req = in_frame || (state_q == ST_REQ);
  assign mdio.mdc      = mdc;
  assign mdio.mdio_o   = mdo_q;
  assign mdio.mdio_oe  = oe_q;

  assign phy_up_o      = stat_q.up;
  assign phy_speed_o   = stat_q.speed;
  assign phy_duplex_o  = stat_q.duplex;
  assign link_change_o = lc_q;
  assign poll_err_o    = err_q;
endmodule

// File: tb/tb_phy_link_poll.sv
// Bench for phy_link_poll: behavioural MDIO PHY, directed scenarios plus random status words.
module tb_phy_link_poll;
  localparam logic [4:0] PA   = 5'h13;
  localparam logic [4:0] SR   = 5'd17;
  localparam int         HALF = 7;
  localparam int         POLL = 200;
  localparam int         GTO  = 300;
  localparam logic [45:0] EXP_FRAME = {32'hFFFF_FFFF, 2'b01, 2'b10, PA, SR};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up, dup, lc, err;
  logic [1:0] spd;

  phy_link_poll_if bus();

  phy_link_poll #(
    .PHY_ADDR(PA), .STAT_REG(SR), .MDC_HALF(HALF), .POLL_CYCLES(POLL), .GNT_TIMEOUT(GTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mdio(bus),
    .phy_up_o(up), .phy_speed_o(spd), .phy_duplex_o(dup),
    .link_change_o(lc), .poll_err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // PHY model: counts MDC rises in a frame, records what the poller drove,
  // presents TA/data for the next rise on each MDC fall.
  logic [15:0] phy_data = 16'h0000;
  logic        nophy = 1'b0;
  logic        phy_mdio = 1'b1;
  int          k = 0;
  logic [45:0] fbits = '0;
  logic [45:0] frames[$];

  assign bus.mdio_i = phy_mdio;

  always @(posedge bus.mdc or negedge bus.mdc or negedge bus.mdio_req or negedge rst_n) begin
    if (!bus.mdio_req || !rst_n) begin
      if (k == 64) frames.push_back(fbits);
      k = 0;
      phy_mdio = 1'b1;
    end else if (bus.mdc) begin
      if (k < 46) fbits = {fbits[44:0], bus.mdio_o};
      k++;
    end else begin
      if (k == 47)                 phy_mdio = nophy;
      else if (k >= 48 && k <= 63) phy_mdio = nophy ? 1'b1 : phy_data[63-k];
      else                         phy_mdio = 1'b1;
    end
  end

  int lc_cnt = 0;
  int mdc_rises = 0;
  int cyc = 0;
  always @(negedge clk) if (lc === 1'b1) lc_cnt++;
  always @(posedge bus.mdc) mdc_rises++;
  always @(posedge clk) cyc++;

  // Reference status
  logic       exp_up = 1'b0, exp_dup = 1'b0, exp_err = 1'b0;
  logic [1:0] exp_spd = 2'b00;
  int         exp_lc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_good(input logic [15:0] d);
    logic nu, nd;
    logic [1:0] ns;
    nu = d[10] & d[11];
    ns = (d[15:14] == 2'b11) ? 2'b00 : d[15:14];
    nd = d[13];
    if ({nu, ns, nd} != {exp_up, exp_spd, exp_dup}) exp_lc++;
    exp_up = nu; exp_spd = ns; exp_dup = nd; exp_err = 1'b0;
  endtask

  task automatic ref_nophy();
    if (exp_up) exp_lc++;
    exp_up = 1'b0; exp_err = 1'b1;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_up"},  up,     exp_up);
    chk({tag, "_spd"}, spd,    exp_spd);
    chk({tag, "_dup"}, dup,    exp_dup);
    chk({tag, "_err"}, err,    exp_err);
    chk({tag, "_lc"},  lc_cnt, exp_lc);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_nframes"}, frames.size(), 1);
    if (frames.size() > 0) chk({tag, "_bits"}, frames.pop_front(), EXP_FRAME);
    frames.delete();
  endtask

  task automatic wait_req_rise(output bit ok);
    int n = 0;
    while (!bus.mdio_req && n < POLL + GTO + 100) begin @(negedge clk); n++; end
    ok = bus.mdio_req;
  endtask

  task automatic poll(input string tag);
    bit ok;
    int n = 0;
    wait_req_rise(ok);
    while (bus.mdio_req && n < GTO + 1200) begin @(negedge clk); n++; end
    chk({tag, "_poll_done"}, ok && !bus.mdio_req, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit   ok;
    int   n, c0, r0;
    time  t1, t2;
    logic [15:0] d;

    bus.mdio_gnt = 1'b1;
    phy_data = 16'hAC00;
    repeat (3) @(negedge clk);
    chk("rst_req",  bus.mdio_req, 0);
    chk("rst_mdc",  bus.mdc,      0);
    chk("rst_mdo",  bus.mdio_o,   1);
    chk("rst_oe",   bus.mdio_oe,  0);
    chk("rst_up",   up,  0);
    chk("rst_spd",  spd, 0);
    chk("rst_dup",  dup, 0);
    chk("rst_lc",   lc,  0);
    chk("rst_err",  err, 0);

    // 1: first frame right after reset, 1000M FD link up
    rst_n = 1'b1;
    n = 0;
    while (!bus.mdio_oe && n < 10) begin @(negedge clk); n++; end
    chk("first_start_le2", bus.mdio_oe && n <= 2, 1);
    c0 = cyc;
    @(posedge bus.mdc); t1 = $time;
    @(posedge bus.mdc); t2 = $time;
    chk("mdc_period", (t2 - t1) / 10, 2 * HALF);
    n = 0;
    while (!up && n < 2000) begin @(negedge clk); n++; end
    chk("frame_len", (cyc - c0 >= 128 * HALF) && (cyc - c0 <= 128 * HALF + 2), 1);
    repeat (3) @(negedge clk);
    ref_good(16'hAC00);
    check_outs("p1");
    check_frame("p1");

    // 2: 100M FD, link down; then identical reads
    phy_data = 16'h6800;
    poll("p2"); ref_good(16'h6800); check_outs("p2"); check_frame("p2");
    for (int i = 0; i < 2; i++) begin
      poll("p2_same"); ref_good(16'h6800); check_outs("p2_same"); check_frame("p2_same");
    end

    // Random status words
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      phy_data = d;
      poll("rnd"); ref_good(d); check_outs("rnd"); check_frame("rnd");
    end
    phy_data = 16'hAC00;
    poll("pre3"); ref_good(16'hAC00); check_outs("pre3"); frames.delete();

    // 3: no PHY answers
    nophy = 1'b1;
    poll("nophy1"); ref_nophy(); check_outs("nophy1"); check_frame("nophy1");
    poll("nophy2"); ref_nophy(); check_outs("nophy2"); check_frame("nophy2");
    nophy = 1'b0;
    poll("restore"); ref_good(16'hAC00); check_outs("restore"); check_frame("restore");

    // 4: grant never comes
    bus.mdio_gnt = 1'b0;
    wait_req_rise(ok);
    chk("gto_req_seen", ok, 1);
    r0 = mdc_rises;
    n = 0;
    while (bus.mdio_req && n < GTO + 50) begin @(negedge clk); n++; end
    chk("gto_req_cycles", n, GTO);
    chk("gto_no_mdc", mdc_rises - r0, 0);
    repeat (2) @(negedge clk);
    exp_err = 1'b1;
    check_outs("gto");
    bus.mdio_gnt = 1'b1;

    // 5: grant pulled during DATA
    phy_data = 16'h0000;
    wait_req_rise(ok);
    n = 0;
    while (k < 54 && n < 3000) begin @(negedge clk); n++; end
    chk("abort_reached_data", ok && k == 54, 1);
    bus.mdio_gnt = 1'b0;
    @(posedge clk); #1;
    chk("abort_oe",  bus.mdio_oe,  0);
    chk("abort_mdc", bus.mdc,      0);
    chk("abort_req", bus.mdio_req, 0);
    repeat (3) @(negedge clk);
    exp_err = 1'b1;
    check_outs("abort");
    chk("abort_nframes", frames.size(), 0);
    bus.mdio_gnt = 1'b1;
    phy_data = 16'h4C00;
    poll("after_abort"); ref_good(16'h4C00); check_outs("after_abort"); check_frame("after_abort");

    // 6: async reset during CMD
    wait_req_rise(ok);
    n = 0;
    while (k < 36 && n < 3000) begin @(negedge clk); n++; end
    chk("rst_mid_in_cmd", ok && k == 36 && up, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rstmid_oe",  bus.mdio_oe,  0);
    chk("rstmid_req", bus.mdio_req, 0);
    chk("rstmid_up",  up,           0);
    chk("rstmid_mdc", bus.mdc,      0);
    repeat (3) @(negedge clk);
    frames.delete();
    exp_up = 1'b0; exp_spd = 2'b00; exp_dup = 1'b0; exp_err = 1'b0;
    rst_n = 1'b1;
    phy_data = 16'h6800;
    poll("post_rst"); ref_good(16'h6800); check_outs("post_rst"); check_frame("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
